// File: rtl/lvds_tx_pixel_packer_if.sv
// Pixel-in / word-pair-out bundle for lvds_tx_pixel_packer.
// The master drives pixels and the downstream ready; the slave is the packer.
interface lvds_tx_pixel_packer_if;
  logic [23:0] I_pix_data;
  logic        I_hs;
  logic        I_vs;
  logic        I_de;
  logic        I_valid;
  logic        O_ready;
  logic [27:0] O_lvds_a_data;
  logic [27:0] O_lvds_b_data;
  logic        O_word_valid;
  logic        I_word_ready;

  modport master (
    output I_pix_data, I_hs, I_vs, I_de, I_valid, I_word_ready,
    input  O_ready, O_lvds_a_data, O_lvds_b_data, O_word_valid
  );

  modport slave (
    input  I_pix_data, I_hs, I_vs, I_de, I_valid, I_word_ready,
    output O_ready, O_lvds_a_data, O_lvds_b_data, O_word_valid
  );
endinterface

// File: rtl/lvds_tx_pixel_packer.sv
// Pairs incoming pixels into dual-channel 4x7-bit LVDS lane words (VESA or JEIDA).
// Optional macro LVDS_TX_BIST_EN adds I_bist_en and a counter test pattern.
module lvds_tx_pixel_packer #(
  parameter int MAP_JEIDA = 0,
  parameter int SWAP_AB   = 0
) (
  input  logic I_clk_1x,
  input  logic I_rst_n,
`ifdef LVDS_TX_BIST_EN
  input  logic I_bist_en,
`endif
  lvds_tx_pixel_packer_if.slave bus,
  output logic O_pair_err
);

  typedef enum logic {EVEN, ODD} state_e;

  state_e      state_q, state_d;
  logic [23:0] held_pix_q;
  logic        held_hs_q, held_vs_q, held_de_q;
  logic [27:0] a_q, b_q, a_d, b_d;
  logic        word_valid_q, pair_err_q, run_q;
  logic        xfer, load, de_rise, err_d;
  logic [27:0] even_word, odd_word;
`ifdef LVDS_TX_BIST_EN
  logic [7:0]  bist_cnt_q;
`endif

  // Lane n occupies [7n+6:7n]; returns {lane3, lane2, lane1, lane0}.
  function automatic logic [27:0] map_pixel(input logic [23:0] pix,
                                            input logic hs, input logic vs,
                                            input logic de);
    logic [7:0] r, g, b;
    r = pix[23:16];
    g = pix[15:8];
    b = pix[7:0];
    if (MAP_JEIDA != 0)
      map_pixel = {1'b0, b[1:0], g[1:0], r[1:0],
                   de, vs, hs, b[7:4],
                   b[3:2], g[7:3],
                   g[2], r[7:2]};
    else
      map_pixel = {1'b0, b[7:6], g[7:6], r[7:6],
                   de, vs, hs, b[5:2],
                   b[1:0], g[5:1],
                   g[0], r[5:0]};
  endfunction

  // run_q keeps O_ready low until the first clock after reset release.
  assign bus.O_ready       = run_q & (~word_valid_q | bus.I_word_ready);
  assign xfer              = bus.I_valid & bus.O_ready;
  assign bus.O_lvds_a_data = a_q;
  assign bus.O_lvds_b_data = b_q;
  assign bus.O_word_valid  = word_valid_q;
  assign O_pair_err        = pair_err_q;

  assign even_word = map_pixel(held_pix_q, held_hs_q, held_vs_q, held_de_q);
  assign odd_word  = map_pixel(bus.I_pix_data, bus.I_hs, bus.I_vs, bus.I_de);

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    de_rise = 1'b0;
    err_d   = 1'b0;
    a_d     = '0;
    b_d     = '0;
    unique case (state_q)
      EVEN: if (xfer) state_d = ODD;
      ODD: if (xfer) begin
        load = 1'b1;
        if (!held_de_q && bus.I_de) begin
          // Active video starts: flush the blank pixel alone, new pixel becomes even.
          de_rise = 1'b1;
          a_d     = even_word;
          b_d     = even_word;
        end else begin
          state_d = EVEN;
          err_d   = (held_de_q ^ bus.I_de) | (held_vs_q ^ bus.I_vs);
          if (SWAP_AB != 0) begin
            a_d = odd_word;
            b_d = even_word;
          end else begin
            a_d = even_word;
            b_d = odd_word;
          end
        end
      end
    endcase
`ifdef LVDS_TX_BIST_EN
    if (load && I_bist_en) begin
      a_d   = map_pixel({3{bist_cnt_q}}, 1'b0, 1'b0, 1'b1);
      b_d   = a_d;
      err_d = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= EVEN;
    else          state_q <= state_d;
  end

  // NOTE: the held pixel is reset too, so a reset mid-pair leaves no stale data behind.
  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n) begin
      run_q        <= 1'b0;
      held_pix_q   <= '0;
      held_hs_q    <= 1'b0;
      held_vs_q    <= 1'b0;
      held_de_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      word_valid_q <= 1'b0;
      pair_err_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (xfer && (state_q == EVEN || de_rise)) begin
        held_pix_q <= bus.I_pix_data;
        held_hs_q  <= bus.I_hs;
        held_vs_q  <= bus.I_vs;
        held_de_q  <= bus.I_de;
      end
      if (load) begin
        a_q          <= a_d;
        b_q          <= b_d;
        word_valid_q <= 1'b1;
      end else if (bus.I_word_ready) begin
        word_valid_q <= 1'b0;
      end
      if (err_d) pair_err_q <= 1'b1;
    end
  end

`ifdef LVDS_TX_BIST_EN
  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n)                bist_cnt_q <= '0;
    else if (load && I_bist_en)  bist_cnt_q <= bist_cnt_q + 8'd1;
  end
`endif

endmodule

// File: tb/tb_lvds_tx_pixel_packer.sv
// Directed bench for lvds_tx_pixel_packer: three instances (VESA, JEIDA, VESA swapped)
// driven with identical stimulus and compared against hand-computed lane words.
module tb_lvds_tx_pixel_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lvds_tx_pixel_packer_if if0 ();
  lvds_tx_pixel_packer_if if1 ();
  lvds_tx_pixel_packer_if if2 ();
  logic err0, err1, err2;

  lvds_tx_pixel_packer #(.MAP_JEIDA(0), .SWAP_AB(0)) dut_vesa (
    .I_clk_1x(clk), .I_rst_n(rst_n),
`ifdef LVDS_TX_BIST_EN
    .I_bist_en(1'b0),
`endif
    .bus(if0), .O_pair_err(err0));

  lvds_tx_pixel_packer #(.MAP_JEIDA(1), .SWAP_AB(0)) dut_jeida (
    .I_clk_1x(clk), .I_rst_n(rst_n),
`ifdef LVDS_TX_BIST_EN
    .I_bist_en(1'b0),
`endif
    .bus(if1), .O_pair_err(err1));

  lvds_tx_pixel_packer #(.MAP_JEIDA(0), .SWAP_AB(1)) dut_swap (
    .I_clk_1x(clk), .I_rst_n(rst_n),
`ifdef LVDS_TX_BIST_EN
    .I_bist_en(1'b0),
`endif
    .bus(if2), .O_pair_err(err2));

  // ctl = {hs, vs, de}; a_v/b_v are VESA words, a_j/b_j JEIDA words, channels unswapped.
  typedef struct {
    string       name;
    logic [23:0] pe;
    logic [2:0]  ce;
    logic [23:0] po;
    logic [2:0]  co;
    logic [27:0] a_v, b_v, a_j, b_j;
  } vec_t;

  vec_t vecs[4];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [23:0] pix, input logic [2:0] ctl, input logic v);
    if0.I_pix_data = pix; if0.I_hs = ctl[2]; if0.I_vs = ctl[1]; if0.I_de = ctl[0]; if0.I_valid = v;
    if1.I_pix_data = pix; if1.I_hs = ctl[2]; if1.I_vs = ctl[1]; if1.I_de = ctl[0]; if1.I_valid = v;
    if2.I_pix_data = pix; if2.I_hs = ctl[2]; if2.I_vs = ctl[1]; if2.I_de = ctl[0]; if2.I_valid = v;
  endtask

  task automatic set_wr(input logic w);
    if0.I_word_ready = w;
    if1.I_word_ready = w;
    if2.I_word_ready = w;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [23:0] pix, input logic [2:0] ctl);
    int n;
    n = 0;
    drive(pix, ctl, 1'b1);
    #1;
    while (!if0.O_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!if0.O_ready) begin
      errors++;
      $display("FAIL send_timeout: actual O_ready=0 required 1 within 50 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    drive(24'h0, 3'b000, 1'b0);
  endtask

  task automatic check_words(input string name, input logic [27:0] a_v, input logic [27:0] b_v,
                             input logic [27:0] a_j, input logic [27:0] b_j);
    check({name, "_valid"}, {31'd0, if0.O_word_valid}, 32'd1);
    check({name, "_vesa_a"}, {4'd0, if0.O_lvds_a_data}, {4'd0, a_v});
    check({name, "_vesa_b"}, {4'd0, if0.O_lvds_b_data}, {4'd0, b_v});
    check({name, "_jeida_a"}, {4'd0, if1.O_lvds_a_data}, {4'd0, a_j});
    check({name, "_jeida_b"}, {4'd0, if1.O_lvds_b_data}, {4'd0, b_j});
    check({name, "_swap_a"}, {4'd0, if2.O_lvds_a_data}, {4'd0, b_v});
    check({name, "_swap_b"}, {4'd0, if2.O_lvds_b_data}, {4'd0, a_v});
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, {31'd0, if0.O_word_valid}, 32'd0);
    check({name, "_ready"}, {31'd0, if0.O_ready}, 32'd0);
    check({name, "_err"}, {29'd0, err0, err1, err2}, 32'd0);
    check({name, "_a"}, {4'd0, if0.O_lvds_a_data | if1.O_lvds_a_data}, 32'd0);
    check({name, "_b"}, {4'd0, if0.O_lvds_b_data | if2.O_lvds_b_data}, 32'd0);
  endtask

  task automatic release_reset(input string name);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({name, "_ready_at_release"}, {31'd0, if0.O_ready}, 32'd0);
    @(negedge clk);
    check({name, "_ready_after_release"}, {31'd0, if0.O_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"basic", 24'hFF0000, 3'b001, 24'h00FF00, 3'b001,
                28'h070003F, 28'h1900FC0, 28'h070003F, 28'h1900FC0};
    vecs[1] = '{"nibbles", 24'h0F0F0F, 3'b111, 24'hF0F0F0, 3'b111,
                28'h01CF3CF, 28'h7FF0C30, 28'h7FC30C3, 28'h01FCF3C};
    vecs[2] = '{"ctl_per_chan", 24'h000000, 3'b101, 24'h000000, 3'b001,
                28'h0140000, 28'h0100000, 28'h0140000, 28'h0100000};
    vecs[3] = '{"reversed", 24'hF0F0F0, 3'b001, 24'h0F0F0F, 3'b001,
                28'h7F30C30, 28'h010F3CF, 28'h013CF3C, 28'h7F030C3};

    rst_n = 1'b0;
    drive(24'h0, 3'b000, 1'b0);
    set_wr(1'b1);
    repeat (3) @(negedge clk);
    check_zero("reset");
    release_reset("init");

    for (int i = 0; i < 4; i++) begin
      send(vecs[i].pe, vecs[i].ce);
      send(vecs[i].po, vecs[i].co);
      check_words(vecs[i].name, vecs[i].a_v, vecs[i].b_v, vecs[i].a_j, vecs[i].b_j);
    end
    check("table_no_pair_err", {29'd0, err0, err1, err2}, 32'd0);

    // Backpressure: first pair parks, third pixel waits, both pairs emerge in order.
    @(negedge clk);
    set_wr(1'b0);
    send(24'hFF0000, 3'b001);
    send(24'h00FF00, 3'b001);
    check("bp_ready_low", {31'd0, if0.O_ready}, 32'd0);
    drive(24'h0F0F0F, 3'b111, 1'b1);
    repeat (3) @(negedge clk);
    check_words("bp_hold", vecs[0].a_v, vecs[0].b_v, vecs[0].a_j, vecs[0].b_j);
    set_wr(1'b1);
    #1;
    check("bp_ready_release", {31'd0, if0.O_ready}, 32'd1);
    send(24'h0F0F0F, 3'b111);
    check("bp_first_drained", {31'd0, if0.O_word_valid}, 32'd0);
    send(24'hF0F0F0, 3'b111);
    check_words("bp_second", vecs[1].a_v, vecs[1].b_v, vecs[1].a_j, vecs[1].b_j);

    // DE rise on the odd slot, then a pair that loads while the duplicate drains.
    send(24'h0F0F0F, 3'b110);
    send(24'hF0F0F0, 3'b111);
    check_words("de_rise_dup", 28'h00CF3CF, 28'h00CF3CF, 28'h7EC30C3, 28'h7EC30C3);
    send(24'h0F0F0F, 3'b111);
    check_words("de_rise_next", 28'h7FF0C30, 28'h01CF3CF, 28'h01FCF3C, 28'h7FC30C3);
    check("de_rise_no_err", {29'd0, err0, err1, err2}, 32'd0);

    // Pair error is sticky across later clean pairs.
    send(24'h000000, 3'b001);
    send(24'h000000, 3'b000);
    check("pair_err_set", {29'd0, err0, err1, err2}, 32'd7);
    send(vecs[2].pe, vecs[2].ce);
    send(vecs[2].po, vecs[2].co);
    check_words("pair_err_clean", vecs[2].a_v, vecs[2].b_v, vecs[2].a_j, vecs[2].b_j);
    check("pair_err_sticky", {29'd0, err0, err1, err2}, 32'd7);

    // Reset with an even pixel held; the next two pixels must pair cleanly.
    send(24'hFF0000, 3'b001);
    rst_n = 1'b0;
    #1;
    check_zero("mid_pair_reset");
    release_reset("mid_pair");
    send(vecs[1].pe, vecs[1].ce);
    send(vecs[1].po, vecs[1].co);
    check_words("post_reset", vecs[1].a_v, vecs[1].b_v, vecs[1].a_j, vecs[1].b_j);
    check("post_reset_no_err", {29'd0, err0, err1, err2}, 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lvds_tx_pixel_packer.md
LVDS_TX_PIXEL_PACKER -- requirements
Module: lvds_tx_pixel_packer

Interface
REQ-001 Parameter MAP_JEIDA, default 0, selects the lane bit mapping: 0 = VESA, 1 = JEIDA.
REQ-002 Parameter SWAP_AB, default 0, selects channel order: 0 = even pixel on channel A, 1 = even pixel on channel B.
REQ-003 I_clk_1x  input  1  single clock for all logic; one clock, no other clock domains.
REQ-004 I_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 I_pix_data  input  24  pixel colour: R = [23:16], G = [15:8], B = [7:0].
REQ-006 I_hs, I_vs, I_de  input  1 each  sync and data-enable signals, qualified with the pixel.
REQ-007 I_valid  input  1  pixel present this cycle.
REQ-008 O_ready  output  1  packer accepts the pixel this cycle; transfer happens when I_valid and O_ready are both 1.
REQ-009 O_lvds_a_data, O_lvds_b_data  output  28 each  four 7-bit lane words per channel; lane n = [7n+6:7n], bit 6 sent first.
REQ-010 O_word_valid  output  1  output word pair valid.
REQ-011 I_word_ready  input  1  downstream serializer takes the word this cycle.
REQ-012 O_pair_err  output  1  sticky pairing error flag.

Function
REQ-013 Pairing FSM states: EVEN (waiting for first pixel), ODD (holding the even pixel, waiting for the second).
- EVEN + transfer -> ODD; latch the even pixel.
- ODD + transfer -> EVEN; form the word pair.
REQ-014 Word pair load: the word pair loads into the output register on the clock edge that accepts the odd pixel; O_word_valid rises on the next cycle (latency 1 clock after the odd pixel).
REQ-015 Output hold: the output register is held stable while O_word_valid=1 and I_word_ready=0.
REQ-016 O_ready = !O_word_valid | I_word_ready; a pixel is never dropped.
REQ-017 Simultaneous load and drain: on the same cycle (O_word_valid=1, I_word_ready=1, odd pixel accepted), the new pair replaces the old pair and O_word_valid stays 1.
REQ-018 VESA lane mapping (MSB to LSB):
- lane0 = {G0, R5..R0}
- lane1 = {B1, B0, G5..G1}
- lane2 = {DE, VS, HS, B5..B2}
- lane3 = {0, B7, B6, G7, G6, R7, R6}
REQ-019 JEIDA lane mapping (MSB to LSB):
- lane0 = {G2, R7..R2}
- lane1 = {B3, B2, G7..G3}
- lane2 = {DE, VS, HS, B7..B4}
- lane3 = {0, B1, B0, G1, G0, R1, R0}
REQ-020 Channel control bits: each channel's HS/VS/DE bits come from its own pixel.
REQ-021 DE-rise realignment: if an accepted pixel has DE=1 while the FSM is in ODD holding a pixel with DE=0:
- the held pixel is emitted alone, duplicated on both channels;
- the new pixel becomes the even pixel, so active video always starts on the even slot.
- If the output register is busy, O_ready is held low until the duplicate is emitted.
REQ-022 O_pair_err sets when a completed pair has differing DE, or differing VS, between even and odd pixels; it clears only on reset.

Reset
REQ-023 While I_rst_n=0: FSM = EVEN, O_word_valid=0, O_ready=0, O_pair_err=0, O_lvds_a_data=0, O_lvds_b_data=0.
REQ-024 Assertion takes effect asynchronously; deassertion is used synchronously to I_clk_1x. O_ready rises one clock after release.
REQ-025 Reset mid-pair discards the held even pixel and any undrained word.

Configuration
REQ-026 Macro LVDS_TX_BIST_EN defined:
- adds input I_bist_en (1 bit);
- while I_bist_en=1, input pixels are still accepted and paired, but every word pair carries an incrementing 8-bit counter replicated into R, G and B, with HS=VS=0 and DE=1;
- the counter steps by 1 per emitted pair, wraps 255 -> 0, and is 0 after reset.
REQ-027 Macro LVDS_TX_BIST_EN undefined: no I_bist_en port and no counter logic.

Verification
REQ-028 Basic VESA pair: with MAP_JEIDA=0, push pixels 0xFF0000 then 0x00FF00, both DE=1 -> one clock after the second pixel, O_lvds_a_data lane0=7'h3F, lane2=7'h40, and O_lvds_b_data lane1=7'h1F.
REQ-029 JEIDA pair: with MAP_JEIDA=1, the same stimulus -> A lane0=7'h3F, A lane3=7'h03.
REQ-030 Backpressure: hold I_word_ready=0 and stream 4 pixels -> O_ready=0 after the first pair; on release, both pairs come out in order with no loss.
REQ-031 DE rise on odd slot: blank pixel (DE=0), then active pixel (DE=1) -> blank pixel emitted duplicated on A and B; the active pixel appears on channel A of the next pair.
REQ-032 Pair error: pair with DE=1 / DE=0 -> O_pair_err=1, and it stays 1 until I_rst_n is pulsed.
REQ-033 Reset mid-pair: assert I_rst_n low with an even pixel held -> all outputs 0 immediately; after release, the next two pixels form a clean pair.
